// File: rtl/fetch_stage.sv
// Fetch stage: fetches one instruction at a time from imem and hands {mask, pc, insn} to decode.
// Optional perf counters are built when FETCH_STAGE_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned NUM_LANES   = 8,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF,
  parameter int unsigned INSN_BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] exec_mask_in,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  output logic                 imem_req_valid,
  output logic [63:0]          imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic                 dec_valid,
  output logic [63:0]          dec_pc,
  output logic [31:0]          dec_insn,
  output logic [NUM_LANES-1:0] dec_exec_mask,
  input  logic                 dec_ack,
  output logic                 halted,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt
);

  typedef enum logic [1:0] {StReq, StWait, StSend, StHalt} state_e;

  state_e                 state_q, state_d;
  logic [63:0]            pc_q, pc_d;
  logic                   discard_q, discard_d;
  logic                   req_valid_q;
  logic                   pkt_load;
  logic [63:0]            pkt_pc_q;
  logic [31:0]            pkt_insn_q;
  logic [NUM_LANES-1:0]   pkt_mask_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    pkt_load  = 1'b0;
    unique case (state_q)
      StReq: begin
        if (req_valid_q && imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            pkt_load = 1'b1;
            state_d  = StSend;
          end
        end
      end
      StSend: begin
        if (dec_ack) begin
          if (pkt_insn_q[7:0] == HALT_OPCODE) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + 64'(INSN_BYTES);
            state_d = StReq;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StReq;
    endcase

    // Redirect wins; a request already accepted (or still unanswered) leaves one stale response.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      pkt_load = 1'b0;
      state_d  = StReq;
      if ((state_q == StWait && !imem_rsp_valid) ||
          (state_q == StReq && req_valid_q && imem_req_ready)) begin
        discard_d = 1'b1;
        state_d   = StWait;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      req_valid_q <= 1'b0;
      pkt_pc_q    <= '0;
      pkt_insn_q  <= '0;
      pkt_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      // Registered so every output reads 0 while reset is held.
      req_valid_q <= (state_d == StReq);
      if (pkt_load) begin
        pkt_pc_q   <= pc_q;
        pkt_insn_q <= imem_rsp_data;
        pkt_mask_q <= exec_mask_in;
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign dec_valid      = (state_q == StSend);
  assign dec_pc         = pkt_pc_q;
  assign dec_insn       = pkt_insn_q;
  assign dec_exec_mask  = pkt_mask_q;
  assign halted         = (state_q == StHalt);

`ifdef FETCH_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (dec_valid) begin
      if (dec_ack) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      else         stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, directed corner cases, randomized run
// against a packet-stream reference model.
module tb_fetch_stage;

`ifdef FETCH_STAGE_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif
  localparam logic [63:0] ResetPc = 64'h0;

  logic        clk, reset_n;
  logic [7:0]  exec_mask_in;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [63:0] dec_pc;
  logic [31:0] dec_insn;
  logic [7:0]  dec_exec_mask;
  logic        dec_ack, halted;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;

  fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .exec_mask_in   (exec_mask_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .dec_insn       (dec_insn),
    .dec_exec_mask  (dec_exec_mask),
    .dec_ack        (dec_ack),
    .halted         (halted),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs for the coming rising edge, then move to the next falling edge.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic ack,
                       input logic rdir, input logic [63:0] rpc);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    dec_ack        = ack;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[7:2] == 6'h3B) ? 32'h0000_00FF : {a[29:2], 4'h1};
  endfunction

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ack;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_dv;
    logic [63:0] e_pc;
    logic [31:0] e_insn;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_pc, rpc, paddr, prev_pc;
    logic [31:0] prev_insn, last_data, rd;
    logic [7:0]  last_mask;
    logic        m_halt, pend, rdy, rv, ack, rdir, prev_hold;
    int          cnt, nfetch, nstall, idle;

    // Sequential fetch, 1-cycle imem, decode acks as soon as a packet appears.
    tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 32'h1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h4, 1'b0, 64'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h2, 1'b0, 1'b0, 64'h4, 1'b0, 64'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h4, 1'b1, 64'h4, 32'h2};
    tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8, 1'b0, 64'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 32'h3, 1'b0, 1'b0, 64'h8, 1'b0, 64'h0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h8, 1'b1, 64'h8, 32'h3};
    tbl[10] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'hC, 1'b0, 64'h0, 32'h0};

    reset_n = 1'b0;
    exec_mask_in = 8'hA5;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dec_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, ResetPc);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_insn", dec_insn, 0);
    chk("rst_dec_mask", dec_exec_mask, 0);
    chk("rst_halted", halted, 0);
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_stall", perf_stall_cnt, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("seq%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
      chk($sformatf("seq%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("seq%0d_dec_valid", i), dec_valid, tbl[i].e_dv);
      if (tbl[i].e_dv) begin
        chk($sformatf("seq%0d_dec_pc", i), dec_pc, tbl[i].e_pc);
        chk($sformatf("seq%0d_dec_insn", i), dec_insn, tbl[i].e_insn);
        chk($sformatf("seq%0d_dec_mask", i), dec_exec_mask, 8'hA5);
      end
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].ack, 1'b0, 64'h0);
    end

    // Back-pressure: packet at 0xC held for 5 cycles.
    drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 64'h0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_dec_valid", dec_valid, 1);
      chk("bp_dec_pc", dec_pc, 64'hC);
      chk("bp_dec_insn", dec_insn, 32'h4);
      chk("bp_no_req", imem_req_valid, 0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    end
    chk("bp_perf_stall", perf_stall_cnt, PerfOn ? 64'd5 : 64'd0);
    chk("bp_perf_fetch", perf_fetch_cnt, PerfOn ? 64'd3 : 64'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    chk("bp_next_req", imem_req_valid, 1);
    chk("bp_next_addr", imem_req_addr, 64'h10);
    chk("bp_perf_fetch2", perf_fetch_cnt, PerfOn ? 64'd4 : 64'd0);

    // HALT at 0x10, then redirect out of it.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 32'hFF, 1'b0, 1'b0, 64'h0);
    chk("halt_pkt_pc", dec_pc, 64'h10);
    chk("halt_not_yet", halted, 0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    chk("halt_set", halted, 1);
    for (int k = 0; k < 20; k++) begin
      chk("halt_no_req", imem_req_valid, 0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h40);
    chk("unhalt_halted", halted, 0);
    chk("unhalt_req", imem_req_valid, 1);
    chk("unhalt_addr", imem_req_addr, 64'h40);

    // Redirect while waiting; the stale 0xDEAD response must be dropped.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h100);
    chk("stale_wait_no_req", imem_req_valid, 0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("stale_dv0", dec_valid, 0);
    drive(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 64'h0);
    chk("stale_dv1", dec_valid, 0);
    chk("stale_insn_seen", dec_insn == 32'hDEAD, 0);
    chk("stale_req", imem_req_valid, 1);
    chk("stale_addr", imem_req_addr, 64'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("stale_dv2", dec_valid, 0);

    // Redirect coincident with dec_ack of the packet at 0x8.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8);
    chk("rd8_addr", imem_req_addr, 64'h8);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 64'h0);
    chk("ackrd_pc", dec_pc, 64'h8);
    chk("ackrd_insn", dec_insn, 32'h33);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h200);
    chk("ackrd_dv", dec_valid, 0);
    chk("ackrd_req", imem_req_valid, 1);
    chk("ackrd_addr", imem_req_addr, 64'h200);
    chk("ackrd_perf_fetch", perf_fetch_cnt, PerfOn ? 64'd6 : 64'd0);

    // Redirect in the same cycle a request is accepted.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h300);
    chk("reqrd_no_req", imem_req_valid, 0);
    drive(1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b0, 64'h0);
    chk("reqrd_dv", dec_valid, 0);
    chk("reqrd_req", imem_req_valid, 1);
    chk("reqrd_addr", imem_req_addr, 64'h300);
    chk("reqrd_perf_stall", perf_stall_cnt, PerfOn ? 64'd5 : 64'd0);

    // Asynchronous reset while a packet is pending.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 64'h0);
    chk("arst_pre_dv", dec_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dv", dec_valid, 0);
    chk("arst_req", imem_req_valid, 0);
    chk("arst_addr", imem_req_addr, ResetPc);
    chk("arst_dec_pc", dec_pc, 0);
    chk("arst_perf_fetch", perf_fetch_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 32'hBAD, 1'b0, 1'b0, 64'h0);
    chk("arst_inflight_dv", dec_valid, 0);
    chk("arst_first_req", imem_req_valid, 1);
    chk("arst_first_addr", imem_req_addr, ResetPc);

    // Randomized run against the packet-stream model.
    exp_pc = ResetPc; m_halt = 1'b0; pend = 1'b0; cnt = 0; paddr = '0;
    last_data = '0; last_mask = '0; nfetch = 0; nstall = 0; idle = 0;
    prev_hold = 1'b0; prev_pc = '0; prev_insn = '0;
    for (int c = 0; c < 4000; c++) begin
      chk("rnd_req_with_pkt", imem_req_valid & dec_valid, 0);
      chk("rnd_halted", halted, m_halt);
      if (m_halt) chk("rnd_req_in_halt", imem_req_valid, 0);
      if (dec_valid && prev_hold) begin
        chk("rnd_hold_pc", dec_pc, prev_pc);
        chk("rnd_hold_insn", dec_insn, prev_insn);
      end

      exec_mask_in = 8'($urandom);
      rv = 1'b0;
      rd = '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rv = 1'b1;
          rd = mem(paddr);
          pend = 1'b0;
          last_data = rd;
          last_mask = exec_mask_in;
        end
      end
      rdy = 1'($urandom_range(0, 1));
      if (imem_req_valid && rdy) begin
        pend = 1'b1;
        paddr = imem_req_addr;
        cnt = int'($urandom_range(1, 3));
      end

      ack = ($urandom_range(0, 9) < 6);
      idle++;
      if (dec_valid && ack) begin
        chk("rnd_pkt_pc", dec_pc, exp_pc);
        chk("rnd_pkt_insn", dec_insn, mem(exp_pc));
        chk("rnd_pkt_rsp", dec_insn, last_data);
        chk("rnd_pkt_mask", dec_exec_mask, last_mask);
        nfetch++;
        idle = 0;
        if (mem(exp_pc) == 32'hFF) m_halt = 1'b1;
        else exp_pc = exp_pc + 64'd4;
      end else if (dec_valid) begin
        nstall++;
      end

      rdir = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      rpc = 64'($urandom_range(0, 255)) << 2;
      if (rdir) begin
        exp_pc = rpc;
        m_halt = 1'b0;
        idle = 0;
      end

      if (idle > 200) begin
        checks++;
        errors++;
        $display("FAIL rnd_liveness: no packet in %0d cycles at expected pc 0x%0h", idle, exp_pc);
        break;
      end

      prev_hold = dec_valid && !ack && !rdir;
      prev_pc   = dec_pc;
      prev_insn = dec_insn;
      drive(rdy, rv, rd, ack, rdir, rpc);
    end
    chk("rnd_progress", nfetch > 50, 1);
    chk("rnd_perf_fetch", perf_fetch_cnt, PerfOn ? 64'(nfetch) : 64'd0);
    chk("rnd_perf_stall", perf_stall_cnt, PerfOn ? 64'(nstall) : 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
